// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam int unsigned DEFAULT_INSTR_BYTES  = 4;

endpackage

// File: rtl/param_adder.sv
// Parameterised ripple adder with carry-in and carry-out.
module param_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // One extra bit holds the carry-out.
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: PC register, single-outstanding imem
// request handshake, IF/ID output register and EX redirect handling.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
  parameter int unsigned      INSTR_BYTES  = DEFAULT_INSTR_BYTES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [WIDTH-1:0] if_pc,
  output logic [WIDTH-1:0] if_instr,
  output logic [WIDTH-1:0] pc_plus
);

  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             if_valid_q, if_valid_d;
  logic [WIDTH-1:0] if_pc_q, if_pc_d;
  logic [WIDTH-1:0] if_instr_q, if_instr_d;
  logic [WIDTH-1:0] redirect_target;
  logic             adder_cout;
  logic             unused_bits;

  // Carry-out is dropped so the PC wraps modulo 2^WIDTH.
  param_adder #(.WIDTH(WIDTH)) u_pc_adder (
    .a    (pc_q),
    .b    (WIDTH'(INSTR_BYTES)),
    .cin  (1'b0),
    .sum  (pc_plus),
    .cout (adder_cout)
  );

  assign redirect_target = {redirect_pc[WIDTH-1:2], 2'b00};
  assign unused_bits     = ^{adder_cout, redirect_pc[1:0]};

  // Next-state logic; a redirect overrides every non-reset event.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if (redirect_valid) begin
      pc_d       = redirect_target;
      if_valid_d = 1'b0;
      // A request already granted must have its response drained first.
      case (state_q)
        REQ:         state_d = imem_gnt ? DRAIN : REQ;
        WAIT, DRAIN: state_d = imem_rvalid ? REQ : DRAIN;
        default:     state_d = REQ;
      endcase
    end else begin
      case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (imem_gnt) state_d = WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            if_instr_d = imem_rdata;
            if_pc_d    = pc_q;
            pc_d       = pc_plus;
            if_valid_d = 1'b1;
            state_d    = HOLD;
          end
        end
        HOLD: begin
          if (if_ready) begin
            if_valid_d = 1'b0;
            state_d    = REQ;
          end
        end
        DRAIN: begin
          if (imem_rvalid) state_d = REQ;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_VECTOR;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  assign imem_req  = (state_q == REQ);
  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit with a responding memory model.
`timescale 1ns/1ps
module tb_pc_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] pc_plus;

  exp_t        sb_q[$];
  logic [31:0] addr_log[$];
  int          hs_cycle[$];
  int          hs_count = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  bit          gnt_enable = 1'b1;
  int          rv_delay = 1;
  int          discard_cnt = 0;
  bit          const_mode = 1'b0;
  bit          resp_pending = 1'b0;
  int          resp_cnt = 0;
  logic [31:0] resp_addr = '0;
  exp_t        mon_e;

  pc_fetch_unit #(
    .WIDTH       (32),
    .RESET_VECTOR(32'h0000_0000),
    .INSTR_BYTES (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .pc_plus       (pc_plus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return const_mode ? 32'h0000_0013 : (a ^ 32'h5A5A_0013);
  endfunction

  // Memory model: grants while imem_req is seen, answers rv_delay cycles
  // later, and pushes the expected IF/ID transfer unless told to discard it.
  always @(negedge clk) begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (rst) begin
      resp_pending = 1'b0;
    end else if (resp_pending) begin
      if (resp_cnt == 0) begin
        imem_rvalid  = 1'b1;
        imem_rdata   = mem_word(resp_addr);
        resp_pending = 1'b0;
        if (discard_cnt > 0) discard_cnt--;
        else sb_q.push_back({resp_addr, mem_word(resp_addr)});
      end else begin
        resp_cnt--;
      end
    end else if (imem_req && gnt_enable) begin
      imem_gnt     = 1'b1;
      resp_pending = 1'b1;
      resp_cnt     = rv_delay - 1;
      resp_addr    = imem_addr;
      addr_log.push_back(imem_addr);
    end
  end

  // Handshake monitor: every accepted instruction is popped and compared.
  always begin
    @(negedge clk);
    #1;
    if (!rst && if_valid && if_ready) begin
      hs_count++;
      hs_cycle.push_back(cyc);
      n_checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL sb_handshake: got pc=%h instr=%h, expected no instruction", if_pc, if_instr);
      end else begin
        mon_e = sb_q.pop_front();
        if (if_pc !== mon_e.pc || if_instr !== mon_e.instr)
          $display("FAIL sb_handshake: got pc=%h instr=%h, expected pc=%h instr=%h",
                   if_pc, if_instr, mon_e.pc, mon_e.instr);
        else n_pass++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    redirect_valid = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    addr_log.delete();
    hs_cycle.delete();
    hs_count = 0;
    discard_cnt = 0;
  endtask

  // kind 0: hs_count>=n, 1: if_valid, 2: imem_req, 3: grants>=n, 4: req to addr n
  task automatic wait_cond(input int kind, input int n, input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      #2;
      if ((kind == 0 && hs_count >= n) || (kind == 1 && if_valid) ||
          (kind == 2 && imem_req) || (kind == 3 && addr_log.size() >= n) ||
          (kind == 4 && imem_req && imem_addr == 32'(n))) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    if_ready = 1'b1;
    @(negedge clk);
    #2;
    n_checks++;
    if ({imem_req, if_valid} !== 2'b00) $display("FAIL reset_req_valid: got %b want 00", {imem_req, if_valid});
    else n_pass++;
    n_checks++;
    if (if_pc !== 32'h0 || if_instr !== 32'h0)
      $display("FAIL reset_if_regs: got pc=%h instr=%h want 0/0", if_pc, if_instr);
    else n_pass++;
    n_checks++;
    if (imem_addr !== 32'h0) $display("FAIL reset_imem_addr: got %h want 00000000", imem_addr);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    addr_log.delete();
    #2;
    n_checks++;
    if (imem_req !== 1'b0) $display("FAIL first_req_idle: got %b want 0", imem_req);
    else n_pass++;
    @(negedge clk);
    #2;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL first_req: got req=%b addr=%h want 1/00000000", imem_req, imem_addr);
    else n_pass++;
  endtask

  task automatic test_sequential;
    bit ok;
    const_mode = 1'b1;
    rv_delay = 1;
    if_ready = 1'b1;
    do_reset(2);
    wait_cond(0, 3, 40, ok);
    n_checks++;
    if (!ok) $display("FAIL seq_timeout: got %0d handshakes want 3", hs_count);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (addr_log.size() <= i) $display("FAIL seq_addr%0d: got no request want %h", i, 32'(i * 4));
      else if (addr_log[i] !== 32'(i * 4))
        $display("FAIL seq_addr%0d: got %h want %h", i, addr_log[i], 32'(i * 4));
      else n_pass++;
    end
    if (hs_cycle.size() >= 3) begin
      for (int i = 1; i < 3; i++) begin
        n_checks++;
        if (hs_cycle[i] - hs_cycle[i-1] !== 3)
          $display("FAIL seq_interval%0d: got %0d cycles want 3", i, hs_cycle[i] - hs_cycle[i-1]);
        else n_pass++;
      end
    end
    const_mode = 1'b0;
  endtask

  task automatic test_backpressure;
    bit ok;
    if_ready = 1'b0;
    do_reset(2);
    wait_cond(1, 0, 20, ok);
    @(negedge clk);
    if_ready = 1'b1;
    @(negedge clk);
    if_ready = 1'b0;
    wait_cond(1, 0, 20, ok);
    n_checks++;
    if (!ok || if_pc !== 32'h4) $display("FAIL bp_present: got valid=%b pc=%h want 1/00000004", if_valid, if_pc);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #2;
      n_checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== mem_word(32'h4) || imem_req !== 1'b0)
        $display("FAIL bp_hold%0d: got valid=%b pc=%h instr=%h req=%b want 1/00000004/%h/0",
                 i, if_valid, if_pc, if_instr, imem_req, mem_word(32'h4));
      else n_pass++;
    end
    @(negedge clk);
    if_ready = 1'b1;
    wait_cond(2, 0, 20, ok);
    n_checks++;
    if (!ok || imem_addr !== 32'h8) $display("FAIL bp_next_req: got req=%b addr=%h want 1/00000008", imem_req, imem_addr);
    else n_pass++;
  endtask

  task automatic test_redirect_wait;
    bit ok;
    bit leaked;
    if_ready = 1'b1;
    rv_delay = 2;
    do_reset(2);
    wait_cond(4, 8, 40, ok);
    n_checks++;
    if (!ok) $display("FAIL rw_reach8: got addr=%h want request to 00000008", imem_addr);
    else n_pass++;
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0102;
    discard_cnt = 1;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    leaked = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      #2;
      if (if_valid) leaked = 1'b1;
      if (imem_req) ok = 1'b1;
    end
    n_checks++;
    if (leaked || !ok || imem_addr !== 32'h100)
      $display("FAIL rw_target: got leaked=%b req=%b addr=%h want 0/1/00000100", leaked, ok, imem_addr);
    else n_pass++;
    wait_cond(1, 0, 20, ok);
    n_checks++;
    if (!ok || if_pc !== 32'h100) $display("FAIL rw_if_pc: got %h want 00000100", if_pc);
    else n_pass++;
    rv_delay = 1;
  endtask

  task automatic test_redirect_req_gnt;
    bit ok;
    if_ready = 1'b1;
    rv_delay = 3;
    gnt_enable = 1'b0;
    do_reset(2);
    wait_cond(2, 0, 10, ok);
    @(posedge clk);
    #1;
    gnt_enable = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    discard_cnt = 1;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #2;
      n_checks++;
      if (imem_req !== 1'b0 || if_valid !== 1'b0)
        $display("FAIL rg_drain%0d: got req=%b valid=%b want 0/0", i, imem_req, if_valid);
      else n_pass++;
    end
    @(negedge clk);
    #2;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200)
      $display("FAIL rg_target: got req=%b addr=%h want 1/00000200", imem_req, imem_addr);
    else n_pass++;
    wait_cond(1, 0, 20, ok);
    n_checks++;
    if (!ok || if_pc !== 32'h200) $display("FAIL rg_if_pc: got %h want 00000200", if_pc);
    else n_pass++;
    rv_delay = 1;
  endtask

  task automatic test_wrap;
    bit ok;
    if_ready = 1'b1;
    do_reset(2);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    #2;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC || pc_plus !== 32'h0)
      $display("FAIL wrap_first: got req=%b addr=%h pc_plus=%h want 1/fffffffc/00000000",
               imem_req, imem_addr, pc_plus);
    else n_pass++;
    wait_cond(3, 2, 30, ok);
    n_checks++;
    if (!ok || addr_log[1] !== 32'h0)
      $display("FAIL wrap_second: got ok=%b addr=%h want 1/00000000", ok, ok ? addr_log[1] : 32'hx);
    else n_pass++;
    wait_cond(0, 2, 30, ok);
  endtask

  task automatic test_reset_mid;
    bit ok;
    if_ready = 1'b1;
    rv_delay = 3;
    do_reset(2);
    wait_cond(4, 8, 60, ok);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({imem_req, if_valid} !== 2'b00 || if_pc !== 32'h0 || if_instr !== 32'h0 || imem_addr !== 32'h0)
      $display("FAIL mid_reset: got req=%b valid=%b pc=%h instr=%h addr=%h want all 0",
               imem_req, if_valid, if_pc, if_instr, imem_addr);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    addr_log.delete();
    hs_count = 0;
    rv_delay = 1;
    wait_cond(2, 0, 10, ok);
    n_checks++;
    if (!ok || imem_addr !== 32'h0) $display("FAIL mid_restart: got req=%b addr=%h want 1/00000000", imem_req, imem_addr);
    else n_pass++;
    wait_cond(0, 1, 20, ok);
    n_checks++;
    if (!ok) $display("FAIL mid_fetch: got %0d handshakes want 1", hs_count);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_req_gnt();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction-fetch front end of the 5-stage RISC-V core. Holds the program counter, computes the sequential next PC with one `param_adder` instance, and issues one request at a time to instruction memory over a req/gnt/rvalid handshake. Presents each fetched instruction and its PC to the IF/ID boundary with a valid/ready handshake, and accepts branch/jump redirects from EX.

## Interface
- `WIDTH`: default 32. Address and instruction width.
- `RESET_VECTOR`: default 32'h0000_0000. PC value loaded on reset.
- `INSTR_BYTES`: default 4. Sequential PC increment.

Ports:
- `clk`: in, 1. Single clock; all state updates on the rising edge.
- `rst`: in, 1. Synchronous, active-high reset.
- `redirect_valid`: in, 1. EX requests a PC redirect this cycle.
- `redirect_pc`: in, WIDTH. Redirect target; bits [1:0] are ignored and treated as 0.
- `imem_req`: out, 1. Fetch request to instruction memory.
- `imem_addr`: out, WIDTH. Fetch address; equals `pc` whenever `imem_req` is 1.
- `imem_gnt`: in, 1. Memory accepts the request this cycle.
- `imem_rvalid`: in, 1. Read data is valid this cycle.
- `imem_rdata`: in, WIDTH. Instruction word.
- `if_valid`: out, 1. `if_instr` and `if_pc` hold a fetched instruction.
- `if_ready`: in, 1. Decode accepts the instruction.
- `if_pc`: out, WIDTH. PC of the presented instruction.
- `if_instr`: out, WIDTH. Presented instruction.
- `pc_plus`: out, WIDTH. Combinational `pc + INSTR_BYTES`, also used by the link-address path.

## Operation
- States: IDLE, REQ, WAIT, HOLD, DRAIN.
- Reset, from any state: `pc` = RESET_VECTOR, state = IDLE. `imem_req`, `if_valid`, `if_pc` and `if_instr` are all 0. `imem_addr` = RESET_VECTOR.
- IDLE: moves to REQ on the next cycle.
- REQ:
  - `imem_req` = 1, `imem_addr` = `pc`, both held stable until `imem_gnt`.
  - On `imem_gnt`, go to WAIT.
- WAIT: on `imem_rvalid`:
  - `if_instr` <= `imem_rdata`, `if_pc` <= `pc`, `pc` <= `pc_plus`, `if_valid` <= 1.
  - Go to HOLD.
- HOLD:
  - `if_valid` = 1, and outputs are held stable while `if_ready` = 0.
  - On `if_ready`, `if_valid` <= 0 and go to REQ.
- DRAIN:
  - Waits for the response to a request that a redirect has cancelled.
  - On `imem_rvalid`, discard the data and go to REQ.
- Redirect: `redirect_valid` has priority over all non-reset events. In every case `pc` <= {`redirect_pc`[WIDTH-1:2], 2'b00} and `if_valid` <= 0.
  - IDLE, HOLD, or REQ without `gnt`: go to REQ.
  - REQ with `gnt` in the same cycle, or WAIT without `rvalid`: go to DRAIN.
  - WAIT with `rvalid` in the same cycle: discard the data and go to REQ.
  - DRAIN: update `pc` and stay in DRAIN; if `rvalid` arrives in the same cycle, go to REQ.
  - HOLD with `if_ready` in the same cycle: the instruction counts as consumed, the redirect wins, and `pc` is the redirect target.
- Arithmetic: `pc_plus` = `pc` + INSTR_BYTES, computed by `param_adder` with `cin` = 0. Carry-out is ignored, so PC wraps modulo 2^WIDTH (32'hFFFF_FFFC → 32'h0000_0000).
- At most one outstanding memory request. `imem_rvalid` is ignored in IDLE, REQ and HOLD.
- Instruction memory shares `rst`, so no stale response exists after reset.

## Timing
- Minimum per-instruction latency, with `gnt` immediate and `rvalid` one cycle after `gnt`:
  - REQ at cycle n, WAIT at n+1, `if_valid` = 1 at n+2.
  - With `if_ready` held high, an instruction completes every 3 cycles.
- First `imem_req` is asserted on the second cycle after `rst` deasserts (IDLE, then REQ).
- Redirect takes effect on the next edge: the new `imem_addr` is visible the following cycle, or after DRAIN completes.
- `if_valid`, `if_pc`, `if_instr`, `imem_req` and `imem_addr` are registered or decoded from registered state only. There is no combinational path from `imem_*` inputs or `if_ready` to outputs. `pc_plus` is the only combinational output.

## Structure
- `fetch_pkg`: `fetch_state_t` enum (IDLE, REQ, WAIT, HOLD, DRAIN), default RESET_VECTOR and INSTR_BYTES constants.
- One sub-module: `param_adder #(.WIDTH(WIDTH))` for `pc_plus`, with `b` = INSTR_BYTES and `cin` = 0.
- Remaining logic (FSM, PC register, output registers) stays in one module.

## Test plan
- Reset and sequential fetch:
  - Stimulus: `rst` for 2 cycles; memory returns 32'h0000_0013 for every address; `gnt` immediate; `rvalid` one cycle later; `if_ready` = 1.
  - Required: `imem_addr` sequence 0x0, 0x4, 0x8; `if_pc` matches; `if_valid` pulses every 3 cycles.
- Backpressure:
  - Stimulus: `if_ready` = 0 for 5 cycles in HOLD.
  - Required: `if_valid`, `if_pc` = 0x4 and `if_instr` stable; `imem_req` = 0 throughout; after `if_ready` = 1, the next request is to 0x8.
- Redirect during WAIT:
  - Stimulus: `redirect_pc` = 32'h0000_0102 while waiting on 0x8.
  - Required: the 0x8 response is discarded (`if_valid` stays 0); next `imem_addr` = 0x100; `if_pc` = 0x100.
- Redirect during REQ with a simultaneous `gnt`:
  - Required: DRAIN is entered; exactly one response is discarded; then a request to the target is issued.
- Wrap-around:
  - Stimulus: redirect to 32'hFFFF_FFFC.
  - Required: fetch at 0xFFFF_FFFC, then 0x0000_0000.
- Reset mid-operation:
  - Stimulus: `rst` asserted in WAIT.
  - Required: all outputs return to reset values on the next edge; the fetch restarts at RESET_VECTOR.
